// File: rtl/edisk_pkg.sv
// Shared constants for the E-disk controller: control-register and CPU status-word
// bit positions, plus the page-width helper.
package edisk_pkg;

    localparam int ED_WIN_EN = 5;
    localparam int ED_STK_EN = 4;

    localparam int ST_STACK  = 2;
    localparam int ST_WR_N   = 1;
    localparam int ST_MEMR   = 7;

    // Page 0 is main RAM; every bank of every unit gets its own page after that.
    function automatic int page_w(input int units, input int bank_bits);
        return $clog2(units * (1 << bank_bits) + 1);
    endfunction

endpackage

// File: rtl/edisk_unit.sv
// One E-disk unit: its control register, the port-write load, and the
// stack/window hit flags together with the bank that goes with the hit.
module edisk_unit
    import edisk_pkg::*;
#(
    parameter logic [7:0] PORT      = 8'h10,
    parameter bit         PORT_OK   = 1'b1,
    parameter int         BANK_BITS = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wr_stb_i,
    input  logic [7:0]           addr_lo_i,
    input  logic [7:0]           din_i,
    input  logic                 stack_i,
    input  logic                 window_i,
    input  logic                 mem_i,
    output logic                 sel_o,
    output logic [7:0]           ctrl_o,
    output logic                 stack_hit_o,
    output logic                 win_hit_o,
    output logic [BANK_BITS-1:0] bank_o
);

    logic [7:0]           ctrl_q, ctrl_d;
    logic [BANK_BITS-1:0] win_bank, stk_bank;

    assign sel_o  = PORT_OK && (addr_lo_i == PORT);
    assign ctrl_d = (wr_stb_i && sel_o) ? din_i : ctrl_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ctrl_q <= 8'h00;
        else       ctrl_q <= ctrl_d;
    end

    generate
        if (BANK_BITS == 3) begin : g_bb3
            assign win_bank = {ctrl_q[6], ctrl_q[1:0]};
            assign stk_bank = {ctrl_q[7], ctrl_q[3:2]};
        end else begin : g_bb2
            assign win_bank = ctrl_q[1:0];
            assign stk_bank = ctrl_q[3:2];
        end
    endgenerate

    assign stack_hit_o = ctrl_q[ED_STK_EN] & stack_i & mem_i;
    assign win_hit_o   = ctrl_q[ED_WIN_EN] & window_i & mem_i;
    // A unit with both hits reports its stack bank; stack always wins upstream.
    assign bank_o      = stack_hit_o ? stk_bank : win_bank;
    assign ctrl_o      = ctrl_q;

endmodule

// File: rtl/edisk_ctrl.sv
// Multi-unit E-disk controller: tracks the CPU status word, fans port writes out
// to the units and resolves their hits into a single SDRAM page number.
module edisk_ctrl
    import edisk_pkg::*;
#(
    parameter int         UNITS     = 1,
    parameter logic [7:0] PORT_BASE = 8'h10,
    parameter int         BANK_BITS = 2,
    parameter bit         READBACK  = 1'b0,
    localparam int        PAGE_W    = page_w(UNITS, BANK_BITS)
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 cpu_sync,
    input  logic [7:0]           cpu_dout,
    input  logic [15:0]          addr,
    input  logic                 io_wr,
    input  logic                 io_rd,
    output logic [PAGE_W-1:0]    page,
    output logic                 io_sel,
    output logic [7:0]           io_dout,
    output logic [8*UNITS-1:0]   ctrl_q
);

    localparam int NB = 1 << BANK_BITS;

    generate
        if (UNITS < 1 || UNITS > 8) begin : g_bad_units
            $error("edisk_ctrl: UNITS must be 1..8");
        end
        if (BANK_BITS != 2 && BANK_BITS != 3) begin : g_bad_bb
            $error("edisk_ctrl: BANK_BITS must be 2 or 3");
        end
        if (int'(PORT_BASE) + UNITS - 1 > 255) begin : g_port_wrap
            $warning("edisk_ctrl: port range wraps past 8'hFF, upper units unaddressable");
        end
    endgenerate

    logic       sync_q, io_wr_q, arm_q;
    logic [7:0] status_q;
    logic       stack, mem, window, wr_stb;

    // arm_q blocks the first clock after reset so an io_wr held through reset
    // does not look like a fresh rising edge.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sync_q   <= 1'b0;
            io_wr_q  <= 1'b0;
            arm_q    <= 1'b0;
            status_q <= 8'h02;
        end else begin
            sync_q  <= cpu_sync;
            io_wr_q <= io_wr;
            arm_q   <= 1'b1;
            if (cpu_sync && !sync_q) status_q <= cpu_dout;
        end
    end

    assign stack  = status_q[ST_STACK];
    assign mem    = status_q[ST_MEMR] | ~status_q[ST_WR_N];
    assign window = addr[15] & (addr[14] ^ addr[13]);
    assign wr_stb = io_wr & ~io_wr_q & arm_q;

    logic [UNITS-1:0]                sel, stk_hit, win_hit;
    logic [UNITS-1:0][BANK_BITS-1:0] bank;
    logic [UNITS-1:0][7:0]           ctrl;

    generate
        for (genvar k = 0; k < UNITS; k++) begin : g_unit
            localparam logic [8:0] PSUM = {1'b0, PORT_BASE} + 9'(k);
            edisk_unit #(
                .PORT      (PSUM[7:0]),
                .PORT_OK   (!PSUM[8]),
                .BANK_BITS (BANK_BITS)
            ) u_unit (
                .clk_i       (clk_sys),
                .rst_i       (reset),
                .wr_stb_i    (wr_stb),
                .addr_lo_i   (addr[7:0]),
                .din_i       (cpu_dout),
                .stack_i     (stack),
                .window_i    (window),
                .mem_i       (mem),
                .sel_o       (sel[k]),
                .ctrl_o      (ctrl[k]),
                .stack_hit_o (stk_hit[k]),
                .win_hit_o   (win_hit[k]),
                .bank_o      (bank[k])
            );
        end
    endgenerate

    assign ctrl_q = ctrl;
    assign io_sel = |sel;

    logic [7:0] rd_data;

    // Descending scans let the lowest index win; the stack pass runs last so it wins.
    always_comb begin
        page    = '0;
        rd_data = 8'hFF;
        for (int k = UNITS - 1; k >= 0; k--) begin
            if (win_hit[k]) page = PAGE_W'(1 + k * NB) + PAGE_W'(bank[k]);
        end
        for (int k = UNITS - 1; k >= 0; k--) begin
            if (stk_hit[k]) page = PAGE_W'(1 + k * NB) + PAGE_W'(bank[k]);
        end
        for (int k = UNITS - 1; k >= 0; k--) begin
            if (sel[k]) rd_data = ctrl[k];
        end
    end

    assign io_dout = (READBACK && io_sel && io_rd) ? rd_data : 8'hFF;

    logic unused_bits;
    assign unused_bits = ^{addr[12:8], status_q[6:3], status_q[0]};

endmodule
